// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch stage
// (instruction reads) and the memory stage (loads/stores) of the pipeline.
// Grants one transaction at a time, returns read data with a one-cycle ack,
// and drives stall signals while a requester waits.
//
// Optional feature macro: MEM_ARB_TIMEOUT_EN (busy watchdog, TIMEOUT_CYC param,
// sticky arb_err). Without it the arbiter waits indefinitely and arb_err is 0.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   i_req/i_addr               fetch read request (held until i_ack) / address
//   i_rdata/i_ack              instruction data / one-cycle completion pulse
//   d_read/d_write             load / store request (held until d_ack)
//   d_addr/d_wdata             data address / store data
//   d_rdata/d_ack              load data / one-cycle completion pulse
//   mem_req/mem_we             memory transaction active / write enable
//   mem_addr/mem_wdata         memory address / write data
//   mem_rdata/mem_ready        memory read data / one-cycle completion pulse
//   fetch_stall/mem_stall      combinational pipeline freeze requests
//   arb_err                    sticky watchdog timeout flag
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 16
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        fetch_stall,
    output logic        mem_stall,
    output logic        arb_err
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_I = 2'd2,
        DONE   = 2'd3
    } arbStateT;

    arbStateT         state;
    logic [CNT_W-1:0] starveCnt;
    logic             dataReq;
    logic             dataWins;

    assign dataReq  = d_read | d_write;
    // Data has priority unless fetch has been passed over STARVE_LIMIT times in a row.
    assign dataWins = dataReq & (~i_req | (starveCnt < CNT_W'(STARVE_LIMIT)));

    assign fetch_stall = i_req & ~i_ack;
    assign mem_stall   = dataReq & ~d_ack;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] toCnt;
`else
    assign arb_err = 1'b0;
`endif

    // Arbitration FSM with registered memory-side and requester-side outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            starveCnt <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            toCnt     <= '0;
            arb_err   <= 1'b0;
`endif
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
                    toCnt <= '0;
`endif
                    if (dataWins) begin
                        state     <= BUSY_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_write;   // read+write together counts as a write
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        if (!i_req) begin
                            starveCnt <= '0;
                        end else if (starveCnt < CNT_W'(STARVE_LIMIT)) begin
                            starveCnt <= starveCnt + CNT_W'(1);
                        end
                    end else if (i_req) begin
                        state     <= BUSY_I;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= i_addr;
                        mem_wdata <= '0;
                        starveCnt <= '0;
                    end
                end
                BUSY_D, BUSY_I: begin
                    if (mem_ready) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        if (state == BUSY_I) begin
                            i_ack   <= 1'b1;
                            i_rdata <= mem_rdata;
                        end else begin
                            d_ack <= 1'b1;
                            if (!mem_we) begin
                                d_rdata <= mem_rdata;
                            end
                        end
`ifdef MEM_ARB_TIMEOUT_EN
                    end else if (toCnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        // Watchdog abort: complete the handshake with a poison value.
                        state   <= DONE;
                        mem_req <= 1'b0;
                        arb_err <= 1'b1;
                        if (state == BUSY_I) begin
                            i_ack   <= 1'b1;
                            i_rdata <= 32'hDEADBEEF;
                        end else begin
                            d_ack   <= 1'b1;
                            d_rdata <= 32'hDEADBEEF;
                        end
                    end else begin
                        toCnt <= toCnt + TO_W'(1);
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
